// File: rtl/hfg_feature_accumulator.sv
// Weighted-rectangle summer: registered multiply + adder tree, then framed accumulation.
// Latency: beat sampled -> oValid after $clog2(NUM_REC)+2 cycles; 1 beat/cycle throughput.
// Backpressure: none; invalid beats travel as bubbles and never touch the accumulator.
module hfg_feature_accumulator #(
    parameter int NUM_REC  = 8,
    parameter int REC_W    = 21,
    parameter int WEIGHT_W = 3,
    parameter int ACC_W    = 24
) (
    input  logic                         iClk,
    input  logic                         iReset_n,
    input  logic                         iValid,
    input  logic                         iFirst,
    input  logic                         iLast,
    input  logic [NUM_REC*REC_W-1:0]     iRec,
    input  logic [NUM_REC*WEIGHT_W-1:0]  iWeight,
    output logic signed [ACC_W-1:0]      oFeature,
    output logic                         oValid,
    output logic                         oOverflow,
    output logic                         oDropped
);

    localparam int D  = $clog2(NUM_REC);
    localparam int L  = 1 << D;
    localparam int P  = REC_W + 1 + WEIGHT_W;
    localparam int S  = P + D;
    localparam int E  = ((S > ACC_W) ? S : ACC_W) + 1;
    localparam int NS = D + 2;

    localparam logic signed [E-1:0] MAX_V = {{(E-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [E-1:0] MIN_V = {{(E-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, IN_GROUP} state_t;

    // Padding leaves get zero weight, so they contribute nothing to the tree.
    logic [L*REC_W-1:0]    rec_q;
    logic [L*WEIGHT_W-1:0] weight_q;
    logic [NS-1:0]         vld_sr;
    logic [NS-1:0]         first_sr;
    logic [NS-1:0]         last_sr;

    always_ff @(posedge iClk) begin
        rec_q    <= (L*REC_W)'(iRec);
        weight_q <= (L*WEIGHT_W)'(iWeight);
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
        end else begin
            vld_sr   <= {vld_sr[NS-2:0], iValid};
            first_sr <= {first_sr[NS-2:0], iFirst};
            last_sr  <= {last_sr[NS-2:0], iLast};
        end
    end

    // Level 0 holds the products; each further level halves the node count and grows one bit.
    for (genvar lv = 0; lv <= D; lv++) begin : g_lvl
        localparam int W = P + lv;
        localparam int N = L >> lv;
        logic signed [W-1:0] node [N];

        if (lv == 0) begin : g_mul
            always_ff @(posedge iClk) begin
                for (int k = 0; k < N; k++) begin
                    node[k] <= P'($signed({1'b0, rec_q[k*REC_W +: REC_W]}))
                             * P'($signed(weight_q[k*WEIGHT_W +: WEIGHT_W]));
                end
            end
        end else begin : g_add
            always_ff @(posedge iClk) begin
                for (int i = 0; i < N; i++) begin
                    node[i] <= {g_lvl[lv-1].node[2*i][W-2],   g_lvl[lv-1].node[2*i]}
                             + {g_lvl[lv-1].node[2*i+1][W-2], g_lvl[lv-1].node[2*i+1]};
                end
            end
        end
    end

    logic signed [S-1:0] tree_sum;
    assign tree_sum = g_lvl[D].node[0];

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;
    logic                     cont;
    logic signed [E-1:0]      sum_ext;
    logic signed [ACC_W-1:0]  sat_val;
    logic                     sat_flag;
    logic                     ovf_next;

    // A beat continues the running group only when one is open and it does not restart it.
    always_comb begin
        cont     = (state == IN_GROUP) & ~first_sr[NS-1];
        sum_ext  = E'(tree_sum) + (cont ? E'(acc) : '0);
        sat_flag = 1'b0;
        sat_val  = sum_ext[ACC_W-1:0];
        if (sum_ext > MAX_V) begin
            sat_val  = MAX_V[ACC_W-1:0];
            sat_flag = 1'b1;
        end else if (sum_ext < MIN_V) begin
            sat_val  = MIN_V[ACC_W-1:0];
            sat_flag = 1'b1;
        end
        ovf_next = sat_flag | (cont & ovf);
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            oFeature  <= '0;
            oValid    <= 1'b0;
            oOverflow <= 1'b0;
            oDropped  <= 1'b0;
        end else begin
            oValid   <= 1'b0;
            oDropped <= 1'b0;
            if (vld_sr[NS-1]) begin
                oDropped <= (state == IN_GROUP) & first_sr[NS-1];
                if (last_sr[NS-1]) begin
                    oFeature  <= sat_val;
                    oOverflow <= ovf_next;
                    oValid    <= 1'b1;
                    state     <= IDLE;
                    acc       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    state <= IN_GROUP;
                    acc   <= sat_val;
                    ovf   <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_hfg_feature_accumulator.sv
// Randomized + directed bench for hfg_feature_accumulator against a cycle-indexed group model.
module tb_hfg_feature_accumulator;

    localparam int NUM_REC  = 8;
    localparam int REC_W    = 21;
    localparam int WEIGHT_W = 3;
    localparam int ACC_W    = 24;
    localparam int LAT      = 5;
    localparam longint AMAX = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint AMIN = -(longint'(1) << (ACC_W-1));

    logic                         iClk = 1'b0;
    logic                         iReset_n;
    logic                         iValid;
    logic                         iFirst;
    logic                         iLast;
    logic [NUM_REC*REC_W-1:0]     iRec;
    logic [NUM_REC*WEIGHT_W-1:0]  iWeight;
    logic signed [ACC_W-1:0]      oFeature;
    logic                         oValid;
    logic                         oOverflow;
    logic                         oDropped;

    hfg_feature_accumulator #(
        .NUM_REC (NUM_REC),
        .REC_W   (REC_W),
        .WEIGHT_W(WEIGHT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iValid   (iValid),
        .iFirst   (iFirst),
        .iLast    (iLast),
        .iRec     (iRec),
        .iWeight  (iWeight),
        .oFeature (oFeature),
        .oValid   (oValid),
        .oOverflow(oOverflow),
        .oDropped (oDropped)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rec [NUM_REC];
    int w   [NUM_REC];

    bit     m_in_group;
    bit     m_ovf;
    longint m_acc;
    bit     ex_vld  [16];
    bit     ex_drop [16];
    bit     ex_ovf  [16];
    longint ex_feat [16];
    longint held_feat;
    bit     held_ovf;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_group = 0;
        m_acc      = 0;
        m_ovf      = 0;
        for (int i = 0; i < 16; i++) begin
            ex_vld[i]  = 0;
            ex_drop[i] = 0;
            ex_ovf[i]  = 0;
            ex_feat[i] = 0;
        end
        held_feat = 0;
        held_ovf  = 0;
    endtask

    // Group semantics on a whole beat: weighted sum, saturating running total, framing.
    task automatic model_beat();
        longint s = 0;
        longint t;
        bit     start;
        bit     flag = 0;
        int     slot = (cyc + LAT) % 16;
        for (int k = 0; k < NUM_REC; k++) s += longint'(rec[k]) * longint'(w[k]);
        start         = !m_in_group || iFirst;
        ex_drop[slot] = m_in_group && iFirst;
        t = (start ? 64'sd0 : m_acc) + s;
        if (t > AMAX) begin t = AMAX; flag = 1; end
        else if (t < AMIN) begin t = AMIN; flag = 1; end
        m_ovf = (start ? 1'b0 : m_ovf) | flag;
        if (iLast) begin
            ex_vld[slot]  = 1;
            ex_feat[slot] = t;
            ex_ovf[slot]  = m_ovf;
            m_in_group    = 0;
            m_acc         = 0;
            m_ovf         = 0;
        end else begin
            m_in_group = 1;
            m_acc      = t;
        end
    endtask

    task automatic step();
        int slot;
        @(posedge iClk);
        cyc++;
        if (!iReset_n) model_reset();
        else if (iValid) model_beat();
        #1;
        slot = cyc % 16;
        if (ex_vld[slot]) begin
            held_feat = ex_feat[slot];
            held_ovf  = ex_ovf[slot];
        end
        check_val("valid", oValid, ex_vld[slot]);
        check_val("dropped", oDropped, ex_drop[slot]);
        check_val("feature", $signed(oFeature), held_feat);
        check_val("overflow", oOverflow, held_ovf);
        ex_vld[slot]  = 0;
        ex_drop[slot] = 0;
    endtask

    task automatic drive(input bit v, input bit f, input bit l);
        iValid = v;
        iFirst = f;
        iLast  = l;
        for (int k = 0; k < NUM_REC; k++) begin
            iRec[k*REC_W +: REC_W]          = REC_W'(rec[k]);
            iWeight[k*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(w[k]);
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic set_uniform(input int r, input int wt);
        for (int k = 0; k < NUM_REC; k++) begin
            rec[k] = r;
            w[k]   = wt;
        end
    endtask

    // Beat whose weighted sum is s; the other leaves carry noise under zero weight.
    task automatic set_sum(input int s);
        for (int k = 0; k < NUM_REC; k++) begin
            rec[k] = int'($urandom_range(0, (1 << REC_W) - 1));
            w[k]   = 0;
        end
        rec[0] = s;
        w[0]   = 1;
    endtask

    initial begin
        iReset_n = 0;
        iValid   = 0;
        iFirst   = 0;
        iLast    = 0;
        iRec     = '0;
        iWeight  = '0;
        model_reset();

        set_uniform(5, 1);
        for (int i = 0; i < 3; i++) drive(1, 1, 1);
        iReset_n = 1;
        idle(5);

        for (int k = 0; k < NUM_REC; k++) begin
            rec[k] = k + 1;
            w[k]   = 1;
        end
        drive(1, 1, 1);
        idle(6);

        set_sum(0);
        rec[0] = 1000; w[0] = -1;
        rec[1] = 300;  w[1] = 3;
        drive(1, 1, 1);
        idle(6);

        set_sum(10); drive(1, 1, 0);
        idle(2);
        set_sum(10); drive(1, 0, 0);
        idle(1);
        set_sum(10); drive(1, 0, 1);
        set_sum(7);  drive(1, 1, 1);
        idle(6);

        set_uniform((1 << REC_W) - 1, 3);
        drive(1, 1, 0);
        drive(1, 0, 1);
        set_uniform((1 << REC_W) - 1, -4);
        drive(1, 1, 0);
        drive(1, 0, 1);
        idle(6);

        set_sum(5); drive(1, 1, 0);
        set_sum(7); drive(1, 0, 0);
        set_sum(9); drive(1, 1, 1);
        idle(6);

        set_sum(5); drive(1, 1, 0);
        set_sum(7); drive(1, 0, 0);
        iReset_n = 0;
        idle(2);
        iReset_n = 1;
        idle(6);
        set_sum(4); drive(1, 0, 0);
        set_sum(6); drive(1, 0, 1);
        idle(6);

        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < NUM_REC; k++) begin
                rec[k] = ($urandom % 3 == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(0, (1 << REC_W) - 1));
                w[k]   = int'($urandom_range(0, 7)) - 4;
            end
            iReset_n = ($urandom % 250 != 0);
            drive($urandom % 10 < 7, $urandom % 4 == 0, $urandom % 3 == 0);
            iReset_n = 1;
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
